stack_arbiter: RTL and testbench
================================

STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of request write data, pop return data and the stack data path.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req0_i, req1_i  input  1 each  requester 0/1 operation request, held until granted.
REQ-005 op0_i, op1_i  input  1 each  operation: 0 = push, 1 = pop.
REQ-006 wdata0_i, wdata1_i  input  DATA_WIDTH each  push data.
REQ-007 gnt0_o, gnt1_o  output  1 each  one-cycle grant; the requester's operation is issued to the stack in that cycle.
REQ-008 rvalid0_o, rvalid1_o  output  1 each  pop data valid, one cycle.
REQ-009 rdata_o  output  DATA_WIDTH  popped data, shared by both requesters.
REQ-010 stack_wn_o, stack_rn_o  output  1 each  push and pop strobes to the stack.
REQ-011 stack_in_o  output  DATA_WIDTH  push data to the stack.
REQ-012 stack_out_i  input  DATA_WIDTH  top-of-stack data from the stack.
REQ-013 stack_full_i, stack_empty_i  input  1 each  stack status.
REQ-014 flush_i  input  1  flush request pulse; flush_done_o  output  1  flush-complete pulse.

Function
REQ-015 At most one stack operation per cycle; stack_wn_o and stack_rn_o are never high together.
REQ-016 Eligibility: a request is eligible when req is high and either op=0 with stack_full_i low, or op=1 with stack_empty_i low.
REQ-017 Ineligible requests are neither granted nor dropped; the requester keeps req asserted.
REQ-018 Arbitration is combinational in the grant cycle: one eligible requester is granted; if both are eligible, the requester not granted most recently wins.
REQ-019 The round-robin pointer (last granted) updates only on a grant; the reset value is 1, so requester 0 wins the first tie.
REQ-020 Grant on push: gntN_o=1, stack_wn_o=1, stack_in_o=wdataN_i in the same cycle.
REQ-021 Grant on pop: gntN_o=1, stack_rn_o=1; stack_out_i is registered into rdata_o and rvalidN_o=1 on the next cycle (latency 1).
REQ-022 rdata_o holds its value between pops; rvalid0_o and rvalid1_o are never high together.
REQ-023 Back-to-back grants are allowed every cycle, including alternating requesters.
REQ-024 FSM states: ARB (normal arbitration) and FLUSH.
REQ-025 ARB -> FLUSH on flush_i=1; there are no grants in FLUSH.
REQ-026 In FLUSH, stack_rn_o=1 each cycle stack_empty_i=0, with no rvalid and data discarded.
REQ-027 In FLUSH with stack_empty_i=1: flush_done_o pulses for one cycle, and the next state is ARB.
REQ-028 A flush_i received in FLUSH is ignored.
REQ-029 A flush_i in the same cycle as eligible requests: the flush takes priority, no grant is issued, and the requests remain pending.
REQ-030 A flush_i with the stack already empty: enter FLUSH, then flush_done_o pulses in the following cycle.

Reset
REQ-031 While rst=1, all outputs are 0: gnt*, rvalid*, rdata_o, stack_wn_o, stack_rn_o, stack_in_o and flush_done_o.
REQ-032 While rst=1, the state is ARB and the round-robin pointer is 1.
REQ-033 A reset in FLUSH or between pop grant and rvalid aborts: no rvalid and no flush_done_o is produced afterwards.

Configuration
REQ-034 Macro STACK_ARB_FLUSH_EN, when defined, includes the FLUSH state and flush behaviour per REQ-024..030.
REQ-035 With STACK_ARB_FLUSH_EN undefined, the flush_i and flush_done_o ports remain present, flush_i is ignored, flush_done_o is tied 0, and the FSM is ARB only.

Verification
REQ-036 Empty stack, req0 push 0x00AA -> gnt0_o=1, stack_wn_o=1, stack_in_o=0x00AA in the same cycle.
REQ-037 Stack top 0x1234, req1 pop -> gnt1_o and stack_rn_o that cycle; next cycle rvalid1_o=1, rdata_o=0x1234.
REQ-038 Both requesters push continuously for 4 cycles from reset -> grants in order 0,1,0,1; stack_in_o follows the winner.
REQ-039 stack_full_i=1, req0 push and req1 pop -> gnt1_o only; req0 waits; once full drops, gnt0_o is issued.
REQ-040 STACK_ARB_FLUSH_EN defined, 3 entries held, flush_i pulse with req0 pending -> 3 stack_rn_o cycles with no rvalid, then a flush_done_o pulse, then gnt0_o.
REQ-041 rst asserted mid-flush -> all outputs 0 immediately; no flush_done_o after rst is released.

Source files
------------

// File: rtl/stack_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : stack_arbiter_if
// Purpose  : Requester, stack and flush signals of the two-port stack arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface stack_arbiter_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  req0_i, req1_i;
  logic                  op0_i, op1_i;
  logic [DATA_WIDTH-1:0] wdata0_i, wdata1_i;
  logic                  gnt0_o, gnt1_o;
  logic                  rvalid0_o, rvalid1_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  stack_wn_o, stack_rn_o;
  logic [DATA_WIDTH-1:0] stack_in_o;
  logic [DATA_WIDTH-1:0] stack_out_i;
  logic                  stack_full_i, stack_empty_i;
  logic                  flush_i, flush_done_o;

  // Arbiter side
  modport slave (
    input  req0_i, req1_i, op0_i, op1_i, wdata0_i, wdata1_i,
    input  stack_out_i, stack_full_i, stack_empty_i, flush_i,
    output gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rdata_o,
    output stack_wn_o, stack_rn_o, stack_in_o, flush_done_o
  );

  // Requester / stack environment side
  modport master (
    output req0_i, req1_i, op0_i, op1_i, wdata0_i, wdata1_i,
    output stack_out_i, stack_full_i, stack_empty_i, flush_i,
    input  gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, rdata_o,
    input  stack_wn_o, stack_rn_o, stack_in_o, flush_done_o
  );
endinterface
`default_nettype wire

// File: rtl/stack_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stack_arbiter
// Purpose  : Round-robin arbiter granting two requesters push/pop access to a
//            shared stack. Optional flush feature under STACK_ARB_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stack_arbiter #(
  parameter int DATA_WIDTH = 16
) (
  input  wire logic       clk,
  input  wire logic       rst,
  stack_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  logic                  w_elig0, w_elig1;
  logic                  w_pick0, w_pick1;
  logic                  w_arb_en;
  logic                  w_gnt0, w_gnt1;
  logic                  w_wn, w_rn;
  logic                  w_flush_done;
  logic [DATA_WIDTH-1:0] w_stack_in;

  logic                  r_last;
  logic                  r_rvalid0, r_rvalid1;
  logic [DATA_WIDTH-1:0] r_rdata;

  assign w_elig0 = bus.req0_i & (bus.op0_i ? ~bus.stack_empty_i : ~bus.stack_full_i);
  assign w_elig1 = bus.req1_i & (bus.op1_i ? ~bus.stack_empty_i : ~bus.stack_full_i);

  // r_last holds the most recently granted requester; the other one wins a tie
  assign w_pick1 = w_elig1 & (~w_elig0 | ~r_last);
  assign w_pick0 = w_elig0 & ~w_pick1;

`ifdef STACK_ARB_FLUSH_EN
  state_t r_state, w_state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB;
    end else begin
      r_state <= w_state_nxt;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = bus.flush_i;
`endif

  always_comb begin
    w_arb_en     = 1'b0;
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    w_wn         = 1'b0;
    w_rn         = 1'b0;
    w_flush_done = 1'b0;
    w_stack_in   = '0;
`ifdef STACK_ARB_FLUSH_EN
    w_state_nxt  = r_state;
`endif
    if (!rst) begin
`ifdef STACK_ARB_FLUSH_EN
      case (r_state)
        ARB: begin
          if (bus.flush_i) begin
            w_state_nxt = FLUSH;
          end else begin
            w_arb_en = 1'b1;
          end
        end
        FLUSH: begin
          // Drain the stack one entry per cycle; popped data is discarded
          if (!bus.stack_empty_i) begin
            w_rn = 1'b1;
          end else begin
            w_flush_done = 1'b1;
            w_state_nxt  = ARB;
          end
        end
        default: w_state_nxt = ARB;
      endcase
`else
      w_arb_en = 1'b1;
`endif
      if (w_arb_en) begin
        w_gnt0 = w_pick0;
        w_gnt1 = w_pick1;
        if (w_pick0) begin
          if (bus.op0_i) begin
            w_rn = 1'b1;
          end else begin
            w_wn       = 1'b1;
            w_stack_in = bus.wdata0_i;
          end
        end else if (w_pick1) begin
          if (bus.op1_i) begin
            w_rn = 1'b1;
          end else begin
            w_wn       = 1'b1;
            w_stack_in = bus.wdata1_i;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last    <= 1'b1;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rvalid0 <= w_gnt0 & bus.op0_i;
      r_rvalid1 <= w_gnt1 & bus.op1_i;
      if ((w_gnt0 & bus.op0_i) | (w_gnt1 & bus.op1_i)) begin
        r_rdata <= bus.stack_out_i;
      end
      if (w_gnt0 | w_gnt1) begin
        r_last <= w_gnt1;
      end
    end
  end

  assign bus.gnt0_o       = w_gnt0;
  assign bus.gnt1_o       = w_gnt1;
  assign bus.stack_wn_o   = w_wn;
  assign bus.stack_rn_o   = w_rn;
  assign bus.stack_in_o   = w_stack_in;
  assign bus.flush_done_o = w_flush_done;
  assign bus.rvalid0_o    = r_rvalid0;
  assign bus.rvalid1_o    = r_rvalid1;
  assign bus.rdata_o      = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_stack_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_arbiter
// Purpose  : Self-checking bench for stack_arbiter: vector table, directed
//            reset/flush sequences and randomized traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack_arbiter;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stack_arbiter_if #(.DATA_WIDTH(DW)) bus();
  stack_arbiter #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] stk[$];

  typedef struct packed {
    logic r0, o0, r1, o1, full, empty;
    logic [DW-1:0] w0, w1, sout;
    logic g0, g1, wn, rn, v0, v1;
    logic [DW-1:0] ein, erd;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [38:0] pack(logic g0, logic g1, logic wn, logic rn, logic v0,
                                       logic v1, logic fd, logic [DW-1:0] din, logic [DW-1:0] rd);
    return {g0, g1, wn, rn, v0, v1, fd, din, rd};
  endfunction

  // Push data only matters while the push strobe is up
  function automatic logic [38:0] sample();
    return {bus.gnt0_o, bus.gnt1_o, bus.stack_wn_o, bus.stack_rn_o, bus.rvalid0_o,
            bus.rvalid1_o, bus.flush_done_o, (bus.stack_wn_o ? bus.stack_in_o : 16'h0),
            bus.rdata_o};
  endfunction

  task automatic check(input string name, input logic [38:0] act, input logic [38:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req0_i = 1'b0; bus.op0_i = 1'b0; bus.wdata0_i = '0;
    bus.req1_i = 1'b0; bus.op1_i = 1'b0; bus.wdata1_i = '0;
    bus.flush_i = 1'b0;
  endtask

  task automatic drive_stack();
    bus.stack_empty_i = (stk.size() == 0);
    bus.stack_full_i  = (stk.size() >= DEPTH);
    bus.stack_out_i   = (stk.size() > 0) ? stk[stk.size()-1] : '0;
  endtask

  function automatic logic [53:0] raw_outputs();
    return {bus.gnt0_o, bus.gnt1_o, bus.stack_wn_o, bus.stack_rn_o, bus.rvalid0_o,
            bus.rvalid1_o, bus.flush_done_o, bus.stack_in_o, bus.rdata_o};
  endfunction

  // Reset with live requests on the inputs; every output must read zero
  task automatic do_reset();
    rst = 1'b1;
    bus.req0_i = 1'b1; bus.op0_i = 1'b0; bus.wdata0_i = 16'hFFFF;
    bus.req1_i = 1'b1; bus.op1_i = 1'b1; bus.flush_i = 1'b1;
    bus.stack_empty_i = 1'b0; bus.stack_full_i = 1'b0; bus.stack_out_i = 16'hBEEF;
    @(negedge clk);
    n_checks++;
    if (raw_outputs() !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", raw_outputs());
    end
    idle_inputs();
    stk.delete();
    drive_stack();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drives flush_i on cycle 0 (and optionally cycle 2); the stack follows the DUT strobes
  task automatic run_flush(input int ncyc, input bit pulse2, output int rn_cnt, output int rv_cnt,
                           output int done_cnt, output int done_cyc, output int gnt0_cyc);
    logic s_rn, s_wn;
    logic [DW-1:0] s_in;
    rn_cnt = 0; rv_cnt = 0; done_cnt = 0; done_cyc = -1; gnt0_cyc = -1;
    for (int c = 0; c < ncyc; c++) begin
      bus.flush_i = (c == 0) || (pulse2 && c == 2);
      drive_stack();
      @(negedge clk);
      s_rn = bus.stack_rn_o; s_wn = bus.stack_wn_o; s_in = bus.stack_in_o;
      if (s_rn) rn_cnt++;
      if (bus.rvalid0_o || bus.rvalid1_o) rv_cnt++;
      if (bus.flush_done_o) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (bus.gnt0_o && gnt0_cyc < 0) gnt0_cyc = c;
      @(posedge clk);
      if (s_rn && stk.size() > 0) void'(stk.pop_back());
      if (s_wn) stk.push_back(s_in);
      #1;
      if (gnt0_cyc >= 0) bus.req0_i = 1'b0;
    end
    bus.flush_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rn_cnt, rv_cnt, done_cnt, done_cyc, gnt0_cyc;
    bit pr[2], po[2];
    logic [DW-1:0] pw[2];
    int last, pend, w;
    bit el[2];
    logic [DW-1:0] pend_d, cur_rd, exp_in;
    logic ew, er;

    //           r0 o0 r1 o1 fu em  w0        w1        sout      g0 g1 wn rn v0 v1 ein       erd
    tbl[0]  = '{1, 0, 0, 0, 0, 1, 16'h00AA, 16'h0000, 16'h0000, 1, 0, 1, 0, 0, 0, 16'h00AA, 16'h0000};
    tbl[1]  = '{0, 0, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h1234, 0, 1, 0, 1, 0, 0, 16'h0000, 16'h0000};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h1234, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h1234};
    tbl[3]  = '{1, 0, 1, 0, 0, 0, 16'hA001, 16'hB001, 16'h0000, 1, 0, 1, 0, 0, 0, 16'hA001, 16'h1234};
    tbl[4]  = '{1, 0, 1, 0, 0, 0, 16'hA002, 16'hB001, 16'h0000, 0, 1, 1, 0, 0, 0, 16'hB001, 16'h1234};
    tbl[5]  = '{1, 0, 1, 0, 0, 0, 16'hA002, 16'hB002, 16'h0000, 1, 0, 1, 0, 0, 0, 16'hA002, 16'h1234};
    tbl[6]  = '{1, 0, 1, 0, 0, 0, 16'hA003, 16'hB002, 16'h0000, 0, 1, 1, 0, 0, 0, 16'hB002, 16'h1234};
    tbl[7]  = '{1, 0, 1, 1, 1, 0, 16'h0777, 16'h0000, 16'h5555, 0, 1, 0, 1, 0, 0, 16'h0000, 16'h1234};
    tbl[8]  = '{1, 0, 0, 0, 1, 0, 16'h0777, 16'h0000, 16'h5555, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h5555};
    tbl[9]  = '{1, 0, 0, 0, 0, 0, 16'h0777, 16'h0000, 16'h5555, 1, 0, 1, 0, 0, 0, 16'h0777, 16'h5555};
    tbl[10] = '{1, 1, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h9999, 0, 1, 0, 1, 0, 0, 16'h0000, 16'h5555};
    tbl[11] = '{1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h8888, 1, 0, 0, 1, 0, 1, 16'h0000, 16'h9999};
    tbl[12] = '{1, 1, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h8888};
    tbl[13] = '{1, 1, 1, 0, 0, 1, 16'h0000, 16'h4321, 16'h0000, 0, 1, 1, 0, 0, 0, 16'h4321, 16'h8888};
    tbl[14] = '{0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h8888};
    tbl[15] = '{1, 0, 1, 0, 0, 0, 16'h00F0, 16'h0F00, 16'h0000, 1, 0, 1, 0, 0, 0, 16'h00F0, 16'h8888};

    rst = 1'b1;
    idle_inputs();
    drive_stack();
    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 16; i++) begin
      bus.req0_i = tbl[i].r0; bus.op0_i = tbl[i].o0; bus.wdata0_i = tbl[i].w0;
      bus.req1_i = tbl[i].r1; bus.op1_i = tbl[i].o1; bus.wdata1_i = tbl[i].w1;
      bus.stack_full_i = tbl[i].full; bus.stack_empty_i = tbl[i].empty;
      bus.stack_out_i = tbl[i].sout;
      @(negedge clk);
      check($sformatf("vec%0d", i), sample(),
            pack(tbl[i].g0, tbl[i].g1, tbl[i].wn, tbl[i].rn, tbl[i].v0, tbl[i].v1, 1'b0,
                 tbl[i].ein, tbl[i].erd));
      @(posedge clk); #1;
    end
    idle_inputs();

    // Reset between a pop grant and its rvalid must swallow the rvalid
    do_reset();
    stk.push_back(16'h7777);
    drive_stack();
    bus.req1_i = 1'b1; bus.op1_i = 1'b1;
    @(negedge clk);
    check("pop_gnt", sample(), pack(0, 1, 0, 1, 0, 0, 0, 16'h0, 16'h0));
    #1 rst = 1'b1;
    #1 check("abort_outputs", sample(), pack(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0));
    @(posedge clk); #1;
    rst = 1'b0; bus.req1_i = 1'b0;
    rv_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.rvalid0_o || bus.rvalid1_o || bus.rdata_o != 16'h0) rv_cnt++;
      @(posedge clk); #1;
    end
    check_int("abort_no_rvalid", rv_cnt, 0);

`ifdef STACK_ARB_FLUSH_EN
    // Three entries, flush with req0 push pending; second flush pulse mid-flush is ignored
    do_reset();
    stk.push_back(16'h0001); stk.push_back(16'h0002); stk.push_back(16'h0003);
    bus.req0_i = 1'b1; bus.op0_i = 1'b0; bus.wdata0_i = 16'h0C0C;
    run_flush(8, 1'b1, rn_cnt, rv_cnt, done_cnt, done_cyc, gnt0_cyc);
    check_int("flush_rn_cycles", rn_cnt, 3);
    check_int("flush_rvalid", rv_cnt, 0);
    check_int("flush_done_pulses", done_cnt, 1);
    check_int("flush_done_cycle", done_cyc, 4);
    check_int("flush_then_gnt0_cycle", gnt0_cyc, 5);
    check("flush_rdata_discard", {23'h0, bus.rdata_o}, 39'h0);

    // Flush with the stack already empty: done on the following cycle
    do_reset();
    run_flush(4, 1'b0, rn_cnt, rv_cnt, done_cnt, done_cyc, gnt0_cyc);
    check_int("flush_empty_done_cycle", done_cyc, 1);
    check_int("flush_empty_rn", rn_cnt, 0);

    // Reset in the middle of a flush aborts it
    do_reset();
    stk.push_back(16'h0011); stk.push_back(16'h0022); stk.push_back(16'h0033);
    stk.push_back(16'h0044);
    run_flush(2, 1'b0, rn_cnt, rv_cnt, done_cnt, done_cyc, gnt0_cyc);
    check_int("midflush_rn_before_rst", rn_cnt, 1);
    drive_stack();
    bus.req0_i = 1'b1; bus.op0_i = 1'b0; bus.wdata0_i = 16'h5A5A;
    rst = 1'b1;
    #1 check("midflush_rst_outputs", raw_outputs(), 54'h0);
    @(posedge clk); #1;
    rst = 1'b0; bus.req0_i = 1'b0;
    done_cnt = 0; rn_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      drive_stack();
      @(negedge clk);
      if (bus.flush_done_o) done_cnt++;
      if (bus.stack_rn_o) rn_cnt++;
      @(posedge clk); #1;
    end
    check_int("midflush_no_done_after_rst", done_cnt, 0);
    check_int("midflush_no_rn_after_rst", rn_cnt, 0);
`else
    // Flush disabled: flush_i is ignored and the pending push is granted at once
    do_reset();
    stk.push_back(16'h0001); stk.push_back(16'h0002); stk.push_back(16'h0003);
    bus.req0_i = 1'b1; bus.op0_i = 1'b0; bus.wdata0_i = 16'h0C0C;
    run_flush(6, 1'b1, rn_cnt, rv_cnt, done_cnt, done_cyc, gnt0_cyc);
    check_int("noflush_gnt0_cycle", gnt0_cyc, 0);
    check_int("noflush_done_pulses", done_cnt, 0);
    check_int("noflush_rn_cycles", rn_cnt, 0);
`endif

    // Randomized traffic against a queue-based stack and round-robin model
    do_reset();
    pr[0] = 0; pr[1] = 0; po[0] = 0; po[1] = 0; pw[0] = '0; pw[1] = '0;
    last = 1; pend = -1; pend_d = '0; cur_rd = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pr[i] && $urandom_range(0, 2) != 0) begin
          pr[i] = 1'b1;
          po[i] = 1'($urandom_range(0, 1));
          pw[i] = DW'($urandom);
        end
      end
      bus.req0_i = pr[0]; bus.op0_i = po[0]; bus.wdata0_i = pw[0];
      bus.req1_i = pr[1]; bus.op1_i = po[1]; bus.wdata1_i = pw[1];
      bus.flush_i = 1'b0;
      drive_stack();
      for (int i = 0; i < 2; i++)
        el[i] = pr[i] && (po[i] ? (stk.size() > 0) : (stk.size() < DEPTH));
      if (el[0] && el[1]) w = (last == 0) ? 1 : 0;
      else if (el[0])     w = 0;
      else if (el[1])     w = 1;
      else                w = -1;
      ew = 1'b0; er = 1'b0; exp_in = '0;
      if (w >= 0) begin
        if (po[w]) er = 1'b1;
        else begin ew = 1'b1; exp_in = pw[w]; end
      end
      if (pend >= 0) cur_rd = pend_d;
      @(negedge clk);
      check($sformatf("rand%0d", cyc), sample(),
            pack(w == 0, w == 1, ew, er, pend == 0, pend == 1, 1'b0, exp_in, cur_rd));
      pend = -1;
      if (w >= 0) begin
        last = w;
        if (po[w]) begin
          pend   = w;
          pend_d = stk[stk.size()-1];
          void'(stk.pop_back());
        end else begin
          stk.push_back(pw[w]);
        end
        pr[w] = 1'b0;
      end
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
